// File: rtl/inference_scheduler.sv
// -----------------------------------------------------------------------------
// inference_scheduler
//
// Arbitrates N_CH input frame buffers onto a single MLP classifier. A channel
// with a frame ready is granted round-robin, the MLP is kicked with a one-cycle
// start pulse, and the scheduler waits (bounded by TIMEOUT cycles) for the
// result. A returned result is published as a one-cycle note together with a
// one-hot consume pulse to the buffer that produced the frame. A missing result
// aborts the inference and raises a sticky error flag instead.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   buffer_full    per-channel frame-ready level
//   enable_cnn     global inference enable
//   mode_single    1 = one inference per enable assertion, 0 = continuous
//   clear_err      clears timeout_err (a simultaneous new timeout wins)
//   mlp_valid_out  MLP result-valid pulse, only honoured while waiting
//   mlp_class      MLP result, qualified by mlp_valid_out
//   start_mlp      one-cycle MLP start pulse
//   start_ch       granted channel, stable from start until the wait ends
//   buffer_ack     one-hot, one-cycle consume pulse for the reported channel
//   note_ready     one-cycle result pulse
//   note_ch        channel of the last result
//   note_class     class of the last result
//   timeout_err    sticky timeout flag
//   busy           high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module inference_scheduler #(
    parameter int N_CH    = 4,
    parameter int CH_W    = 2,
    parameter int CLS_W   = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  buffer_full,
    input  logic             enable_cnn,
    input  logic             mode_single,
    input  logic             clear_err,
    input  logic             mlp_valid_out,
    input  logic [CLS_W-1:0] mlp_class,
    output logic             start_mlp,
    output logic [CH_W-1:0]  start_ch,
    output logic [N_CH-1:0]  buffer_ack,
    output logic             note_ready,
    output logic [CH_W-1:0]  note_ch,
    output logic [CLS_W-1:0] note_class,
    output logic             timeout_err,
    output logic             busy
);

    // Wide enough to hold TIMEOUT-1, the last cycle counted in WAIT.
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_READY,
        S_ABORT
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [CH_W-1:0]    last_ch;     // most recent grant; the search starts after it
    logic [TMR_W-1:0]   timer;       // cycles spent in WAIT
    logic               armed;       // single-shot gate, re-armed by enable low

    logic [CH_W-1:0]    grant_ch;    // round-robin winner for the current request set
    logic               grant_found;
    logic [CH_W-1:0]    probe_ch;    // loop scratch for the round-robin search

    logic               any_full;
    logic               take_grant;  // a new inference launches at the next edge
    logic               enter_abort;

    assign any_full = |buffer_full;

    // -------------------------------------------------------------------------
    // Round-robin grant: scan last_ch+1, last_ch+2, ... with wrap, so the
    // channel granted last (including one that just timed out) has the lowest
    // priority. N_CH need not be a power of two, hence the explicit modulo.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_ch    = last_ch;
        grant_found = 1'b0;
        probe_ch    = '0;
        for (int i = 1; i <= N_CH; i++) begin
            probe_ch = CH_W'((int'(last_ch) + i) % N_CH);
            if (!grant_found && buffer_full[probe_ch]) begin
                grant_ch    = probe_ch;
                grant_found = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (enable_cnn && any_full && armed) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                // Committed once started, regardless of enable_cnn.
                next_state = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the last allowed cycle still counts.
                if (mlp_valid_out) begin
                    next_state = S_READY;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    next_state = S_ABORT;
                end
            end
            S_READY: begin
                if (!mode_single && enable_cnn && any_full) begin
                    next_state = S_START;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_ABORT: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    assign take_grant  = (next_state == S_START);
    assign enter_abort = (state == S_WAIT) && (next_state == S_ABORT);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, independent of the
    // order of statements in this block.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            last_ch     <= CH_W'(N_CH - 1);  // first grant lands on channel 0
            timer       <= '0;
            armed       <= 1'b1;
            start_ch    <= '0;
            note_ch     <= '0;
            note_class  <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= next_state;

            if (take_grant) begin
                last_ch  <= grant_ch;
                start_ch <= grant_ch;
            end

            if (state == S_START) begin
                timer <= '0;
            end else if (state == S_WAIT) begin
                timer <= timer + 1'b1;
            end

            // Results are captured only while an inference is outstanding.
            if (state == S_WAIT && mlp_valid_out) begin
                note_ch    <= start_ch;
                note_class <= mlp_class;
            end

            // Single-shot disarms after its one result; seeing enable low
            // re-arms, and takes precedence if both happen together.
            if (state == S_READY && mode_single) begin
                armed <= 1'b0;
            end
            if (!enable_cnn) begin
                armed <= 1'b1;
            end

            // A new timeout beats a simultaneous clear.
            if (enter_abort) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs decoded from the state register and registered fields only
    // -------------------------------------------------------------------------
    assign start_mlp  = (state == S_START);
    assign note_ready = (state == S_READY);
    assign busy       = (state != S_IDLE);
    assign buffer_ack = (state == S_READY) ? (N_CH'(1) << note_ch) : '0;

endmodule

// File: tb/tb_inference_scheduler.sv
// -----------------------------------------------------------------------------
// tb_inference_scheduler
//
// Directed bench for inference_scheduler (N_CH=4, TIMEOUT=8). The stimulus
// process pushes the expected grant and expected note for every inference it
// launches; a monitor on the falling edge pops and compares whenever the DUT
// pulses start_mlp or note_ready, and flags any pulse nothing asked for.
// -----------------------------------------------------------------------------
module tb_inference_scheduler;

    localparam int N_CH    = 4;
    localparam int CH_W    = 2;
    localparam int CLS_W   = 3;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [CLS_W-1:0] cls;
        logic [N_CH-1:0]  ack;
    } note_t;

    logic             clk;
    logic             reset;
    logic [N_CH-1:0]  buffer_full;
    logic             enable_cnn;
    logic             mode_single;
    logic             clear_err;
    logic             mlp_valid_out;
    logic [CLS_W-1:0] mlp_class;
    logic             start_mlp;
    logic [CH_W-1:0]  start_ch;
    logic [N_CH-1:0]  buffer_ack;
    logic             note_ready;
    logic [CH_W-1:0]  note_ch;
    logic [CLS_W-1:0] note_class;
    logic             timeout_err;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [CH_W-1:0] exp_grant[$];
    note_t           exp_note[$];

    inference_scheduler #(
        .N_CH   (N_CH),
        .CH_W   (CH_W),
        .CLS_W  (CLS_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .buffer_full  (buffer_full),
        .enable_cnn   (enable_cnn),
        .mode_single  (mode_single),
        .clear_err    (clear_err),
        .mlp_valid_out(mlp_valid_out),
        .mlp_class    (mlp_class),
        .start_mlp    (start_mlp),
        .start_ch     (start_ch),
        .buffer_ack   (buffer_ack),
        .note_ready   (note_ready),
        .note_ch      (note_ch),
        .note_class   (note_class),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor: compares every start and every note against the scoreboard.
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        note_t           n;
        logic [CH_W-1:0] g;
        if (start_mlp) begin
            if (exp_grant.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: start_mlp with start_ch=%0d, no grant expected", start_ch);
            end else begin
                g = exp_grant.pop_front();
                check("grant_ch", 32'(start_ch), 32'(g));
            end
        end
        if (note_ready) begin
            if (exp_note.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_note: note_ch=%0d note_class=%0d, no note expected", note_ch, note_class);
            end else begin
                n = exp_note.pop_front();
                check("note_ch",    32'(note_ch),    32'(n.ch));
                check("note_class", 32'(note_class), 32'(n.cls));
                check("buffer_ack", 32'(buffer_ack), 32'(n.ack));
            end
        end else if (buffer_ack != '0) begin
            checks++;
            errors++;
            $display("FAIL stray_ack: buffer_ack=0x%0h without note_ready", buffer_ack);
        end
    end

    // Expect a start for channel ch; returns at the falling edge of the start cycle.
    task automatic wait_start(input logic [CH_W-1:0] ch);
        bit seen;
        seen = 1'b0;
        exp_grant.push_back(ch);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (start_mlp) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL start_timeout: no start_mlp within 40 cycles, expected channel %0d", ch);
            void'(exp_grant.pop_back());
        end
    endtask

    // Called at the falling edge of the start cycle: return a result d cycles
    // after start, then check the one-cycle result latency. stop drops enable
    // so the scheduler goes idle after this result.
    task automatic finish_inference(input int d, input logic [CLS_W-1:0] cls,
                                    input logic [CH_W-1:0] ch, input bit stop);
        note_t n;
        repeat (d) @(posedge clk);
        #1;
        mlp_valid_out = 1'b1;
        mlp_class     = cls;
        if (stop) enable_cnn = 1'b0;
        n.ch  = ch;
        n.cls = cls;
        n.ack = 4'b0001 << ch;
        exp_note.push_back(n);
        @(negedge clk);
        check("note_before_edge", 32'(note_ready), 32'd0);
        @(posedge clk);
        #1;
        mlp_valid_out = 1'b0;
        mlp_class     = '0;
        @(negedge clk);
        check("note_latency", 32'(note_ready), 32'd1);
    endtask

    // Global bound so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b0;
        buffer_full   = '0;
        enable_cnn    = 1'b0;
        mode_single   = 1'b0;
        clear_err     = 1'b0;
        mlp_valid_out = 1'b0;
        mlp_class     = '0;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_start_mlp",   32'(start_mlp),   32'd0);
        check("rst_start_ch",    32'(start_ch),    32'd0);
        check("rst_buffer_ack",  32'(buffer_ack),  32'd0);
        check("rst_note_ready",  32'(note_ready),  32'd0);
        check("rst_note_ch",     32'(note_ch),     32'd0);
        check("rst_note_class",  32'(note_class),  32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
        reset       = 1'b1;
        buffer_full = 4'b1111;

        // ---- continuous round-robin 0,1,2,3,0 with start latency ----
        @(posedge clk);
        #1;
        enable_cnn = 1'b1;
        exp_grant.push_back(2'd0);
        @(negedge clk);
        check("start_latency_t",  32'(start_mlp), 32'd0);
        @(negedge clk);
        check("start_latency_t1", 32'(start_mlp), 32'd1);
        finish_inference(5, 3'd1, 2'd0, 1'b0);
        wait_start(2'd1);
        finish_inference(5, 3'd2, 2'd1, 1'b0);
        wait_start(2'd2);
        finish_inference(5, 3'd3, 2'd2, 1'b0);
        wait_start(2'd3);
        finish_inference(5, 3'd4, 2'd3, 1'b0);
        wait_start(2'd0);
        finish_inference(5, 3'd6, 2'd0, 1'b1);
        @(negedge clk);
        check("idle_after_stop", 32'(busy), 32'd0);

        // ---- grant channel 2, class 5; buffer_full drops mid-inference ----
        @(posedge clk);
        #1;
        buffer_full = 4'b0100;
        enable_cnn  = 1'b1;
        wait_start(2'd2);
        buffer_full = 4'b0000;
        finish_inference(3, 3'd5, 2'd2, 1'b1);

        // ---- timeout on channel 2, clear in the same cycle loses ----
        @(posedge clk);
        #1;
        buffer_full = 4'b0100;
        enable_cnn  = 1'b1;
        wait_start(2'd2);
        enable_cnn = 1'b0;
        clear_err  = 1'b1;
        repeat (TIMEOUT) @(posedge clk);
        @(negedge clk);
        check("err_before_timeout", 32'(timeout_err), 32'd0);
        check("busy_last_wait",     32'(busy),        32'd1);
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        @(negedge clk);
        check("err_set_wins",  32'(timeout_err), 32'd1);
        check("abort_no_ack",  32'(buffer_ack),  32'd0);
        check("abort_busy",    32'(busy),        32'd1);
        @(negedge clk);
        check("abort_to_idle", 32'(busy),        32'd0);
        check("err_held",      32'(timeout_err), 32'd1);

        // next grant skips the failed channel
        @(posedge clk);
        #1;
        buffer_full = 4'b1111;
        enable_cnn  = 1'b1;
        wait_start(2'd3);
        finish_inference(3, 3'd7, 2'd3, 1'b1);
        check("err_sticky", 32'(timeout_err), 32'd1);
        @(posedge clk);
        #1;
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        @(negedge clk);
        check("err_cleared", 32'(timeout_err), 32'd0);

        // ---- result on the exact timeout cycle wins ----
        @(posedge clk);
        #1;
        enable_cnn = 1'b1;
        wait_start(2'd0);
        finish_inference(TIMEOUT, 3'd2, 2'd0, 1'b1);
        check("edge_valid_no_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        check("edge_valid_idle", 32'(busy), 32'd0);

        // ---- single-shot: one inference per enable assertion ----
        @(posedge clk);
        #1;
        mode_single = 1'b1;
        enable_cnn  = 1'b1;
        wait_start(2'd1);
        finish_inference(2, 3'd3, 2'd1, 1'b0);
        repeat (10) @(negedge clk);
        check("single_no_rerun", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        enable_cnn = 1'b0;
        @(posedge clk);
        #1;
        enable_cnn = 1'b1;
        wait_start(2'd2);
        finish_inference(2, 3'd4, 2'd2, 1'b0);
        repeat (10) @(negedge clk);
        check("single_no_rerun2", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        enable_cnn  = 1'b0;
        mode_single = 1'b0;

        // ---- reset during WAIT ----
        @(posedge clk);
        #1;
        enable_cnn = 1'b1;
        wait_start(2'd3);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        enable_cnn = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy",        32'(busy),        32'd0);
        check("midrst_start_mlp",   32'(start_mlp),   32'd0);
        check("midrst_start_ch",    32'(start_ch),    32'd0);
        check("midrst_note_ready",  32'(note_ready),  32'd0);
        check("midrst_note_ch",     32'(note_ch),     32'd0);
        check("midrst_note_class",  32'(note_class),  32'd0);
        check("midrst_buffer_ack",  32'(buffer_ack),  32'd0);
        check("midrst_timeout_err", 32'(timeout_err), 32'd0);
        // a late result must be ignored while idle
        @(posedge clk);
        #1;
        mlp_valid_out = 1'b1;
        mlp_class     = 3'd5;
        @(posedge clk);
        #1;
        mlp_valid_out = 1'b0;
        mlp_class     = '0;
        repeat (3) @(negedge clk);
        check("late_valid_busy",  32'(busy),       32'd0);
        check("late_valid_class", 32'(note_class), 32'd0);
        // reset restores the first grant to channel 0
        @(posedge clk);
        #1;
        enable_cnn = 1'b1;
        wait_start(2'd0);
        finish_inference(1, 3'd6, 2'd0, 1'b1);

        repeat (5) @(negedge clk);
        check("grant_queue_drained", 32'(exp_grant.size()), 32'd0);
        check("note_queue_drained",  32'(exp_note.size()),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inference_scheduler.md
INFERENCE_SCHEDULER -- requirements
Module: inference_scheduler

Interface
REQ-001 Parameter N_CH, default 4: number of input frame buffers (channels), 2..16.
REQ-002 Parameter CH_W, default 2: channel index width, ceil(log2(N_CH)).
REQ-003 Parameter CLS_W, default 3: classifier result width.
REQ-004 Parameter TIMEOUT, default 1024: maximum WAIT cycles before abort, at least 2.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 buffer_full  in  N_CH  per-channel frame-ready level.
REQ-009 enable_cnn  in  1  global inference enable.
REQ-010 mode_single  in  1  1 = single-shot, 0 = continuous.
REQ-011 clear_err  in  1  clears timeout_err.
REQ-012 mlp_valid_out  in  1  MLP result-valid pulse.
REQ-013 mlp_class  in  CLS_W  MLP result, qualified by mlp_valid_out.
REQ-014 start_mlp  out  1  one-cycle MLP start pulse.
REQ-015 start_ch  out  CH_W  granted channel, held from START until leaving WAIT.
REQ-016 buffer_ack  out  N_CH  one-hot, one-cycle consume pulse.
REQ-017 note_ready  out  1  one-cycle result pulse.
REQ-018 note_ch  out  CH_W  channel of last result, registered.
REQ-019 note_class  out  CLS_W  class of last result, registered.
REQ-020 timeout_err  out  1  sticky timeout flag.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 States: IDLE, START, WAIT, READY, ABORT; all outputs registered or decoded from state and registers only.
REQ-023 IDLE: if enable_cnn & |buffer_full & armed -> START and latch grant; else stay in IDLE.
REQ-024 Grant: round-robin search from last_ch+1 mod N_CH upward with wrap; last_ch updates to the grant.
REQ-025 START: start_mlp=1 for exactly one cycle; WAIT timer cleared to 0; -> WAIT unconditionally, even if enable_cnn drops.
REQ-026 WAIT: timer increments each cycle; on mlp_valid_out -> READY, capture note_class=mlp_class, note_ch=start_ch.
REQ-027 WAIT timeout: timer==TIMEOUT-1 with mlp_valid_out low -> ABORT; if both occur in the same cycle, valid wins (-> READY).
REQ-028 mlp_valid_out outside WAIT SHALL be ignored: no capture, no state change.
REQ-029 READY: note_ready=1 and buffer_ack[note_ch]=1 for exactly one cycle.
REQ-030 READY exit, continuous mode: if enable_cnn & |buffer_full -> START with a new round-robin grant (one-cycle gap between note_ready and start_mlp); else -> IDLE.
REQ-031 READY exit, single-shot mode: -> IDLE and clear armed; armed re-sets when enable_cnn is seen low.
REQ-032 ABORT: set timeout_err, issue no buffer_ack, -> IDLE; last_ch keeps the failed channel, so the next grant skips it.
REQ-033 timeout_err stays set until clear_err=1; if set and clear fall in the same cycle, set wins.
REQ-034 Latency: enable & full sampled in IDLE at cycle t -> start_mlp at t+1; mlp_valid_out at cycle w -> note_ready at w+1.
REQ-035 Deassertion of buffer_full for the granted channel after the grant SHALL NOT abort the inference in progress.

Reset
REQ-036 While reset=0 at a clk edge: state=IDLE, last_ch=N_CH-1 (first grant is channel 0), timer=0, armed=1.
REQ-037 Reset values: start_mlp=0, buffer_ack=0, note_ready=0, note_ch=0, note_class=0, timeout_err=0, busy=0, start_ch=0.
REQ-038 Reset asserted mid-operation SHALL return the block to IDLE in the same edge; no ack or note is produced.

Verification
REQ-039 N_CH=4, enable=1, buffer_full=4'b1111, continuous, valid 5 cycles after each start -> grants 0,1,2,3,0 in order, one note_ready per grant, acks match.
REQ-040 Grant channel 2, mlp_valid_out with mlp_class=5 -> note_ready one cycle later, note_ch=2, note_class=5, buffer_ack=4'b0100.
REQ-041 No valid for TIMEOUT=8 cycles -> ABORT, timeout_err=1, no ack; next grant is channel 3; clear_err -> timeout_err=0.
REQ-042 Valid on the exact timeout cycle -> READY, timeout_err remains 0.
REQ-043 mode_single=1, enable held high -> exactly one inference; pulse enable low then high -> one more.
REQ-044 reset=0 during WAIT -> next cycle busy=0, all outputs at reset values; later valid ignored.
